// File: rtl/bcd_counter_beep_pkg.sv
// Shared BCD digit type, digit limits and the digit arithmetic helpers
// used by the counter top and its per-digit cells.
package bcd_counter_beep_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;
    localparam bcd_t BCD_MIN = 4'd0;

    function automatic bcd_t clamp_bcd(input bcd_t d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

    function automatic bcd_t bcd_inc(input bcd_t d);
        return (d >= BCD_MAX) ? BCD_MIN : bcd_t'(d + 4'd1);
    endfunction

    function automatic bcd_t bcd_dec(input bcd_t d);
        return (d == BCD_MIN) ? BCD_MAX : bcd_t'(d - 4'd1);
    endfunction

endpackage

// File: rtl/bcd_counter_beep_digit.sv
// One BCD digit of the counter: holds its value, advances on an incoming
// carry/borrow and forwards a carry/borrow when it rolls over.
module bcd_digit
    import bcd_counter_beep_pkg::*;
(
    input  logic CLK,
    input  logic rst,
    input  logic step,
    input  logic up_dn,
    input  logic load,
    input  bcd_t load_digit,
    input  logic carry_in,
    output bcd_t digit,
    output logic carry_out
);

    bcd_t digit_q, digit_d;

    always_comb begin
        digit_d = digit_q;
        if (load) begin
            digit_d = clamp_bcd(load_digit);
        end else if (step && carry_in) begin
            digit_d = up_dn ? bcd_inc(digit_q) : bcd_dec(digit_q);
        end
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            digit_q <= BCD_MIN;
        end else begin
            digit_q <= digit_d;
        end
    end

    // Rolls over on this step: at 9 going up or at 0 going down.
    assign carry_out = carry_in && (up_dn ? (digit_q == BCD_MAX) : (digit_q == BCD_MIN));
    assign digit     = digit_q;

endmodule

// File: rtl/bcd_counter_beep.sv
// Multi-digit BCD up/down counter paced by a prescaler, with a wrap pulse
// and a retriggerable beep that lasts a fixed number of count steps.
module bcd_counter_beep
    import bcd_counter_beep_pkg::*;
#(
    parameter int DIV        = 25000000,
    parameter int DIGITS     = 2,
    parameter int BEEP_STEPS = 1,
    parameter int PW         = 25
) (
    input  logic                  CLK,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tick,
    output logic                  wrap,
    output logic                  beep
);

    localparam int BW = $clog2(BEEP_STEPS + 1);

    logic [PW-1:0] presc_q, presc_d;
    logic          step;
    logic          wrap_now;
    logic          tick_q, tick_d;
    logic          wrap_q, wrap_d;
    logic          beep_q, beep_d;
    logic [BW-1:0] bcnt_q, bcnt_d;

    // Load restarts the interval and suppresses any coincident step.
    always_comb begin
        presc_d = presc_q;
        step    = 1'b0;
        if (load) begin
            presc_d = '0;
        end else if (en) begin
            if (presc_q == PW'(DIV - 1)) begin
                presc_d = '0;
                step    = 1'b1;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        logic c_in;
        logic c_out;

        if (g == 0) begin : g_first
            assign c_in = step;
        end else begin : g_chain
            assign c_in = g_dig[g-1].c_out;
        end

        bcd_digit u_digit (
            .CLK        (CLK),
            .rst        (rst),
            .step       (step),
            .up_dn      (up_dn),
            .load       (load),
            .load_digit (load_val[4*g +: 4]),
            .carry_in   (c_in),
            .digit      (count[4*g +: 4]),
            .carry_out  (c_out)
        );
    end

    assign wrap_now = g_dig[DIGITS-1].c_out;

    // A wrap reloads the step budget even while already beeping.
    always_comb begin
        bcnt_d = bcnt_q;
        beep_d = beep_q;
        tick_d = step;
        wrap_d = wrap_now;
        if (wrap_now) begin
            bcnt_d = BW'(BEEP_STEPS);
            beep_d = 1'b1;
        end else if (step && (bcnt_q != '0)) begin
            bcnt_d = bcnt_q - BW'(1);
            if (bcnt_q == BW'(1)) begin
                beep_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
            beep_q  <= 1'b0;
            bcnt_q  <= '0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
            beep_q  <= beep_d;
            bcnt_q  <= bcnt_d;
        end
    end

    assign tick = tick_q;
    assign wrap = wrap_q;
    assign beep = beep_q;

endmodule

// File: tb/tb_bcd_counter_beep.sv
// Bench for bcd_counter_beep: fixed vector table, hand-written corner
// sequences and a randomized run against an integer-valued reference model.
module tb_bcd_counter_beep;

    localparam int DIV    = 4;
    localparam int DIGITS = 2;
    localparam int BS     = 2;
    localparam int PW     = 2;

    logic       CLK = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       up_dn = 1'b1;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'h00;
    logic [7:0] count;
    logic       tick, wrap, beep;

    logic       en2 = 1'b1;
    logic       up2 = 1'b1;
    logic       load2 = 1'b0;
    logic [3:0] lv2 = 4'h0;
    logic [3:0] count2;
    logic       tick2, wrap2, beep2;

    bcd_counter_beep #(.DIV(DIV), .DIGITS(DIGITS), .BEEP_STEPS(BS), .PW(PW)) dut (
        .CLK(CLK), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
        .count(count), .tick(tick), .wrap(wrap), .beep(beep)
    );

    bcd_counter_beep #(.DIV(4), .DIGITS(1), .BEEP_STEPS(12), .PW(2)) dut2 (
        .CLK(CLK), .rst(rst), .en(en2), .up_dn(up2), .load(load2), .load_val(lv2),
        .count(count2), .tick(tick2), .wrap(wrap2), .beep(beep2)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic       ld;
        logic [7:0] lv;
        logic       up;
        logic [7:0] c;
        logic       t;
        logic       w;
        logic       b;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic ld, input logic [7:0] lv, input logic up,
                       input logic [7:0] c, input logic t, input logic w, input logic b);
        vec_t v;
        v = '{ld, lv, up, c, t, w, b};
        vq.push_back(v);
    endtask

    task automatic idle(input int n, input logic up, input logic [7:0] c, input logic b);
        for (int i = 0; i < n; i++) add(1'b0, 8'h00, up, c, 1'b0, 1'b0, b);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        while (n < 20) begin
            cyc();
            n++;
            if (tick) break;
        end
    endtask

    // Reference model: the count is a plain integer 0..10^DIGITS-1.
    int m_val, m_presc, m_bcnt;
    bit m_tick, m_wrap;

    function automatic int pow10(input int d);
        int r = 1;
        for (int i = 0; i < d; i++) r = r * 10;
        return r;
    endfunction

    function automatic int decode(input logic [4*DIGITS-1:0] lv);
        int v = 0;
        for (int d = 0; d < DIGITS; d++) begin
            int nib = int'((lv >> (4 * d)) & 8'h0F);
            if (nib > 9) nib = 9;
            v += nib * pow10(d);
        end
        return v;
    endfunction

    function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
        logic [4*DIGITS-1:0] r = '0;
        for (int d = 0; d < DIGITS; d++) r[4*d +: 4] = 4'((v / pow10(d)) % 10);
        return r;
    endfunction

    task automatic model_reset();
        m_val = 0; m_presc = 0; m_bcnt = 0; m_tick = 0; m_wrap = 0;
    endtask

    task automatic model_step();
        int mx = pow10(DIGITS) - 1;
        m_tick = 0;
        m_wrap = 0;
        if (load) begin
            m_val   = decode(load_val);
            m_presc = 0;
        end else if (en) begin
            if (m_presc == DIV - 1) begin
                m_presc = 0;
                m_tick  = 1;
                if (up_dn) begin
                    if (m_val == mx) begin m_val = 0; m_wrap = 1; end
                    else m_val++;
                end else begin
                    if (m_val == 0) begin m_val = mx; m_wrap = 1; end
                    else m_val--;
                end
                if (m_wrap) m_bcnt = BS;
                else if (m_bcnt > 0) m_bcnt--;
            end else begin
                m_presc++;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int gaps, wraps;
        bit seen_wrap;

        // Reset state
        rst = 1'b0;
        en  = 1'b1;
        repeat (2) cyc();
        chk("reset_count", count, 8'h00);
        chk("reset_tick", tick, 1'b0);
        chk("reset_wrap", wrap, 1'b0);
        chk("reset_beep", beep, 1'b0);

        // Basic up count 00 -> 10
        up_dn = 1'b1;
        rst   = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            wait_tick(n);
            chk("up_interval", n, 4);
            chk("up_count", count, to_bcd(k));
            chk("up_nowrap", wrap, 1'b0);
        end

        // Vector table: up wrap, beep duration, down borrow/wrap, load cases
        add(1, 8'h98, 1, 8'h98, 0, 0, 0); idle(3, 1, 8'h98, 0);
        add(0, 8'h00, 1, 8'h99, 1, 0, 0); idle(3, 1, 8'h99, 0);
        add(0, 8'h00, 1, 8'h00, 1, 1, 1); idle(3, 1, 8'h00, 1);
        add(0, 8'h00, 1, 8'h01, 1, 0, 1); idle(3, 1, 8'h01, 1);
        add(0, 8'h00, 1, 8'h02, 1, 0, 0);
        add(1, 8'h10, 0, 8'h10, 0, 0, 0); idle(3, 0, 8'h10, 0);
        add(0, 8'h00, 0, 8'h09, 1, 0, 0);
        add(1, 8'h01, 0, 8'h01, 0, 0, 0); idle(3, 0, 8'h01, 0);
        add(0, 8'h00, 0, 8'h00, 1, 0, 0); idle(3, 0, 8'h00, 0);
        add(0, 8'h00, 0, 8'h99, 1, 1, 1); idle(3, 0, 8'h99, 1);
        add(1, 8'h3C, 0, 8'h39, 0, 0, 1); idle(3, 0, 8'h39, 1);
        add(0, 8'h00, 0, 8'h38, 1, 0, 1);
        add(1, 8'hAF, 1, 8'h99, 0, 0, 1); idle(3, 1, 8'h99, 1);
        add(0, 8'h00, 1, 8'h00, 1, 1, 1);

        en = 1'b1;
        foreach (vq[i]) begin
            load     = vq[i].ld;
            load_val = vq[i].lv;
            up_dn    = vq[i].up;
            cyc();
            chk("tbl_count", count, vq[i].c);
            chk("tbl_tick", tick, vq[i].t);
            chk("tbl_wrap", wrap, vq[i].w);
            chk("tbl_beep", beep, vq[i].b);
        end
        load = 1'b0;

        // Enable freeze mid-interval while beeping
        up_dn = 1'b1;
        repeat (2) cyc();
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("frz_count", count, 8'h00);
            chk("frz_tick", tick, 1'b0);
            chk("frz_beep", beep, 1'b1);
        end
        en = 1'b1;
        wait_tick(n);
        chk("frz_resume_interval", n, 2);
        chk("frz_resume_count", count, 8'h01);
        chk("frz_resume_beep", beep, 1'b1);
        wait_tick(n);
        chk("beep_end_interval", n, 4);
        chk("beep_end_count", count, 8'h02);
        chk("beep_end_beep", beep, 1'b0);

        // Async reset between edges with count=57 and beep high
        load = 1'b1; load_val = 8'h99;
        cyc();
        load = 1'b0;
        wait_tick(n);
        chk("pre_rst_wrap", wrap, 1'b1);
        chk("pre_rst_beep", beep, 1'b1);
        load = 1'b1; load_val = 8'h57;
        cyc();
        load = 1'b0;
        chk("pre_rst_count", count, 8'h57);
        cyc();
        #3;
        rst = 1'b0;
        #1;
        chk("arst_count", count, 8'h00);
        chk("arst_tick", tick, 1'b0);
        chk("arst_wrap", wrap, 1'b0);
        chk("arst_beep", beep, 1'b0);
        @(negedge CLK);
        rst = 1'b1;
        wait_tick(n);
        chk("arst_first_interval", n, 4);
        chk("arst_first_count", count, 8'h01);

        // Randomized run against the reference model
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            en   = ($urandom_range(0, 3) != 0);
            load = ($urandom_range(0, 31) == 0);
            load_val = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 63) == 0) up_dn = ~up_dn;
            model_step();
            cyc();
            chk("rnd_count", count, to_bcd(m_val));
            chk("rnd_tick", tick, m_tick);
            chk("rnd_wrap", wrap, m_wrap);
            chk("rnd_beep", beep, (m_bcnt != 0));
        end
        load = 1'b0;

        // Retrigger: one digit, beep longer than the wrap period
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        gaps = 0; wraps = 0; seen_wrap = 0;
        for (int i = 0; i < 400; i++) begin
            cyc();
            if (wrap2) begin
                wraps++;
                seen_wrap = 1;
            end
            if (seen_wrap && !beep2) gaps++;
            if (!seen_wrap && beep2) gaps++;
        end
        chk("retrig_gaps", gaps, 0);
        chk("retrig_wraps", wraps, 10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
